// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux tree: steps the selects, samples each channel after a settle time
// and hands the 4-bit vector downstream over valid/ready. Optional change detect: MUX_SCAN_CHANGE_DET_EN.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    output logic [1:0] sel,
    input  logic       mux_o,
    output logic [3:0] samples,
    output logic       valid,
    input  logic       ready,
`ifdef MUX_SCAN_CHANGE_DET_EN
    output logic       changed,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [3:0]       samples_q, samples_d;
    logic             valid_q, valid_d;
    logic [3:0]       newVec;

    // Channel 3 is the last one sampled, so it is merged straight into the delivered vector.
    assign newVec = {mux_o, shadow_q[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            cnt_q     <= '0;
            shadow_q  <= 4'd0;
            samples_q <= 4'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            samples_q <= samples_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        samples_d = samples_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE: begin
                sel_d = 2'd0;
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = RELOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    shadow_d[sel_q] = mux_o;
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                        cnt_d = RELOAD;
                    end else begin
                        state_d   = OUT;
                        samples_d = newVec;
                        valid_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            OUT: begin
                // In continuous mode the next scan starts on the handshake edge itself.
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    sel_d   = 2'd0;
                    if (cont) begin
                        state_d = SETTLE;
                        cnt_d   = RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
                valid_d = 1'b0;
            end
        endcase
    end

`ifdef MUX_SCAN_CHANGE_DET_EN
    logic [3:0] prev_q, prev_d;
    logic       changed_q, changed_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 4'd0;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            changed_q <= changed_d;
        end
    end

    // The pulse lines up with the first valid cycle because both are set on OUT entry.
    always_comb begin
        prev_d    = prev_q;
        changed_d = 1'b0;
        if (state_q == SETTLE && cnt_q == '0 && sel_q == 2'd3) begin
            prev_d    = newVec;
            changed_d = (newVec != prev_q);
        end
    end

    assign changed = changed_q;
`endif

    assign sel     = sel_q;
    assign samples = samples_q;
    assign valid   = valid_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: directed scans push expected vectors, a monitor pops them
// when valid rises. Build with MUX_SCAN_CHANGE_DET_EN to also check the changed pulse.
module tb_mux_scan_ctrl;

    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] muxIn = 4'd0;
    logic [1:0] sel;
    logic       mux_o;
    logic [3:0] samples;
    logic       valid;
    logic       busy;
`ifdef MUX_SCAN_CHANGE_DET_EN
    logic       changed;
`endif

    int         checkCount = 0;
    int         errorCount = 0;
    logic [4:0] expQ[$];
    logic [3:0] lastVec = 4'd0;
    logic       prevValid = 1'b0;

    mux_scan_ctrl #(.SETTLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cont   (cont),
        .sel    (sel),
        .mux_o  (mux_o),
        .samples(samples),
        .valid  (valid),
        .ready  (ready),
`ifdef MUX_SCAN_CHANGE_DET_EN
        .changed(changed),
`endif
        .busy   (busy)
    );

    // The mux tree itself: combinational select of the driven inputs.
    assign mux_o = muxIn[sel];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Expected changed flag compares against the last vector delivered since reset.
    task automatic pushExp(input logic [3:0] vec);
        expQ.push_back({(vec != lastVec), vec});
        lastVec = vec;
    endtask

    task automatic applyStimulus(input logic [3:0] vec, input bit record);
        @(negedge clk);
        muxIn = vec;
        start = 1'b1;
        if (record) pushExp(vec);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge; optionally glitches channel 2 inside its window.
    task automatic waitValid(input string name, input bit glitch, input logic [3:0] finalVec);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 4 * SC + 4) begin
            @(posedge clk);
            #1;
            k++;
            if (glitch) begin
                if (k >= 2 * SC && k <= 2 * SC + 2) muxIn[2] = ~muxIn[2];
                else if (k == 2 * SC + 3) muxIn[2] = 1'b1;
            end
            if (valid) seen = 1'b1;
            else checkOutput({name, "_sel"}, 8'(sel), 8'((k / SC > 3) ? 3 : k / SC));
        end
        checkOutput({name, "_latency"}, seen ? 8'(k) : 8'd0, 8'(4 * SC));
        if (seen) begin
            checkOutput({name, "_selOut"}, 8'(sel), 8'd3);
            checkOutput({name, "_samples"}, 8'(samples), 8'(finalVec));
            checkOutput({name, "_busy"}, 8'(busy), 8'd1);
        end
    endtask

    initial begin : monitor
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && !prevValid) begin
                if (expQ.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedValid: actual samples=%0h required no output", samples);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sbSamples", 8'(samples), 8'(e[3:0]));
`ifdef MUX_SCAN_CHANGE_DET_EN
                    checkOutput("sbChanged", 8'(changed), 8'(e[4]));
`endif
                end
            end
            prevValid = valid;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstSel", 8'(sel), 8'd0);
        checkOutput("rstSamples", 8'(samples), 8'd0);
        checkOutput("rstValid", 8'(valid), 8'd0);
        checkOutput("rstBusy", 8'(busy), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single-shot scan");
        ready = 1'b1;
        cont = 1'b0;
        applyStimulus(4'b1010, 1'b1);
        checkOutput("ssBusyStart", 8'(busy), 8'd1);
        waitValid("single", 1'b0, 4'b1010);
        @(posedge clk);
        #1;
        checkOutput("ssValidDone", 8'(valid), 8'd0);
        checkOutput("ssBusyDone", 8'(busy), 8'd0);
        checkOutput("ssSelDone", 8'(sel), 8'd0);

        $display("[TB] backpressure");
        ready = 1'b0;
        applyStimulus(4'b0110, 1'b1);
        waitValid("bp", 1'b0, 4'b0110);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bpValidHeld", 8'(valid), 8'd1);
            checkOutput("bpSamplesHeld", 8'(samples), 8'b0110);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpValidDone", 8'(valid), 8'd0);
        checkOutput("bpBusyDone", 8'(busy), 8'd0);

        $display("[TB] continuous mode");
        cont = 1'b1;
        applyStimulus(4'b0011, 1'b1);
        waitValid("cont1", 1'b0, 4'b0011);
        muxIn = 4'b1100;
        pushExp(4'b1100);
        @(posedge clk);
        #1;
        checkOutput("contNoIdle1", 8'(busy), 8'd1);
        checkOutput("contValidLow1", 8'(valid), 8'd0);
        waitValid("cont2", 1'b0, 4'b1100);
        pushExp(4'b1100);
        @(posedge clk);
        #1;
        checkOutput("contNoIdle2", 8'(busy), 8'd1);
        waitValid("cont3", 1'b0, 4'b1100);
        cont = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("contStopBusy", 8'(busy), 8'd0);

        $display("[TB] glitch immunity");
        applyStimulus(4'b0101, 1'b1);
        waitValid("glitch", 1'b1, 4'b0101);
        @(posedge clk);
        #1;

        $display("[TB] abort mid-scan");
        applyStimulus(4'b1111, 1'b0);
        repeat (SC + 1) @(posedge clk);
        #1;
        checkOutput("abortSelBefore", 8'(sel), 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abortSel", 8'(sel), 8'd0);
        checkOutput("abortValid", 8'(valid), 8'd0);
        checkOutput("abortSamples", 8'(samples), 8'd0);
        checkOutput("abortBusy", 8'(busy), 8'd0);
        lastVec = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 1'b1);
        waitValid("afterAbort", 1'b0, 4'b1001);
        repeat (2) @(negedge clk);
        checkOutput("queueEmpty", 8'(expQ.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
